// File: rtl/micro_sequencer_pkg.sv
// Shared constants for the microprogram sequencer and the control-store microcode.
package micro_sequencer_pkg;

  localparam int unsigned SEQ_ADDR_W     = 7;
  localparam int unsigned SEQ_CNT_W      = 16;
  localparam int unsigned SEQ_WDOG_W     = 16;
  localparam int unsigned SEQ_FETCH_ADDR = 0;

  // Next-address select field of a control word.
  typedef enum logic [2:0] {
    SEQ_INC      = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_DISPATCH = 3'd2,
    SEQ_JZ       = 3'd3,
    SEQ_JNZ      = 3'd4,
    SEQ_FETCH    = 3'd5,
    SEQ_HALT     = 3'd6,
    SEQ_RSVD     = 3'd7
  } seq_sel_e;

  // Sequencer run state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/micro_sequencer_if.sv
// Host / control-word / control_unit signals of the microprogram sequencer.
interface micro_sequencer_if
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = SEQ_ADDR_W,
  parameter int unsigned CNT_W  = SEQ_CNT_W
);

  logic              start;
  logic              stall;
  logic              Z_flag;
  logic [ADDR_W-1:0] MBRU;
  logic [2:0]        next_sel;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] addr;
  logic              enable;
  logic              busy;
  logic              finish;
  logic              error;
  logic [CNT_W-1:0]  uinstr_count;

  // Host and datapath side.
  modport master (
    output start, stall, Z_flag, MBRU, next_sel, jump_addr,
    input  addr, enable, busy, finish, error, uinstr_count
  );

  // Sequencer side.
  modport slave (
    input  start, stall, Z_flag, MBRU, next_sel, jump_addr,
    output addr, enable, busy, finish, error, uinstr_count
  );

endinterface

// File: rtl/micro_sequencer_next_addr_logic.sv
// Combinational next-microaddress selection; flags reserved selects and increments past the top.
module micro_sequencer_next_addr_logic
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W     = SEQ_ADDR_W,
  parameter int unsigned FETCH_ADDR = SEQ_FETCH_ADDR
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        next_sel,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] mbru,
  input  logic              z_flag,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);

  logic [ADDR_W-1:0] addr_inc;
  logic              at_top;

  assign addr_inc = addr + ADDR_W'(1);
  assign at_top   = &addr;

  // Any select that may fall through to addr+1 is illegal at the top address, even if taken.
  always_comb begin
    next_addr = addr;
    illegal   = 1'b0;
    case (seq_sel_e'(next_sel))
      SEQ_INC:      begin next_addr = addr_inc; illegal = at_top; end
      SEQ_JUMP:     next_addr = jump_addr;
      SEQ_DISPATCH: next_addr = mbru;
      SEQ_JZ:       begin next_addr = z_flag ? jump_addr : addr_inc; illegal = at_top; end
      SEQ_JNZ:      begin next_addr = z_flag ? addr_inc : jump_addr; illegal = at_top; end
      SEQ_FETCH:    next_addr = ADDR_W'(FETCH_ADDR);
      SEQ_HALT:     next_addr = addr;
      SEQ_RSVD:     illegal = 1'b1;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: control-store address register, run FSM, host handshake and counters.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W     = SEQ_ADDR_W,
  parameter int unsigned FETCH_ADDR = SEQ_FETCH_ADDR,
  parameter int unsigned CNT_W      = SEQ_CNT_W,
  parameter logic [SEQ_WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  micro_sequencer_if.slave bus
);

  localparam int unsigned WDOG_W = SEQ_WDOG_W;

  seq_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              finish_q;
  logic              error_q;
  logic [CNT_W-1:0]  count_q;
  logic [WDOG_W-1:0] wdog_q;

  logic [ADDR_W-1:0] next_addr;
  logic              illegal;
  logic [WDOG_W-1:0] wdog_inc;
  logic              wdog_hit;
  logic              halt_sel;

  micro_sequencer_next_addr_logic #(
    .ADDR_W    (ADDR_W),
    .FETCH_ADDR(FETCH_ADDR)
  ) u_next (
    .addr     (addr_q),
    .next_sel (bus.next_sel),
    .jump_addr(bus.jump_addr),
    .mbru     (bus.MBRU),
    .z_flag   (bus.Z_flag),
    .next_addr(next_addr),
    .illegal  (illegal)
  );

  assign wdog_inc = wdog_q + WDOG_W'(1);
  assign wdog_hit = (WDOG_LIMIT != '0) && (wdog_inc == WDOG_LIMIT);
  assign halt_sel = (seq_sel_e'(bus.next_sel) == SEQ_HALT);

  // Run FSM with registered address, status and counters; aborts take priority over HALT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= ADDR_W'(FETCH_ADDR);
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= '0;
      wdog_q   <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            addr_q  <= ADDR_W'(FETCH_ADDR);
            count_q <= '0;
            error_q <= 1'b0;
            wdog_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.stall) begin
            if (!(&count_q)) count_q <= count_q + CNT_W'(1);
            wdog_q <= wdog_inc;
            if (illegal || wdog_hit) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else if (halt_sel) begin
              finish_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_DONE;
            end else begin
              addr_q <= next_addr;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // enable follows stall within the cycle so a held control word never executes twice.
  assign bus.enable       = (state_q == ST_RUN) && !bus.stall;
  assign bus.addr         = addr_q;
  assign bus.busy         = busy_q;
  assign bus.finish       = finish_q;
  assign bus.error        = error_q;
  assign bus.uinstr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a per-cycle behavioural model and literal pins.
module tb_micro_sequencer;

  localparam int LIMIT = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n;

  micro_sequencer_if #(.ADDR_W(7), .CNT_W(16)) bus ();

  micro_sequencer #(
    .ADDR_W    (7),
    .FETCH_ADDR(0),
    .CNT_W     (16),
    .WDOG_LIMIT(16'hFFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 run, 2 done.
  int m_mode, m_pc, m_cnt, m_err, m_fin, m_wd;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    int sel, tgt;
    bit bad;
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_err = 0; m_fin = 0; m_wd = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_fin = 0;
      if (m_mode == 0) begin
        if (bus.start) begin
          m_mode = 1; m_pc = 0; m_cnt = 0; m_err = 0; m_wd = 0;
        end
      end else if (m_mode == 1) begin
        if (!bus.stall) begin
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          m_wd = m_wd + 1;
          sel = int'(bus.next_sel);
          tgt = m_pc;
          bad = 1'b0;
          if ((sel == 0 || sel == 3 || sel == 4) && m_pc == 127) bad = 1'b1;
          if (sel == 7) bad = 1'b1;
          if (sel == 0) tgt = m_pc + 1;
          if (sel == 1) tgt = int'(bus.jump_addr);
          if (sel == 2) tgt = int'(bus.MBRU);
          if (sel == 3) tgt = bus.Z_flag ? int'(bus.jump_addr) : m_pc + 1;
          if (sel == 4) tgt = bus.Z_flag ? m_pc + 1 : int'(bus.jump_addr);
          if (sel == 5) tgt = 0;
          if (bad || (LIMIT != 0 && m_wd == LIMIT)) begin
            m_err = 1; m_mode = 2;
          end else if (sel == 6) begin
            m_fin = 1; m_mode = 2;
          end else begin
            m_pc = tgt;
          end
        end
      end else begin
        m_mode = 0;
      end
    end
  end

  // Literal expectations set by the stimulus; -1 means don't care.
  bit    pin_on = 1'b0;
  string pin_name = "";
  int    pin_addr, pin_cnt, pin_busy, pin_fin, pin_err;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: model every cycle, plus any pending literal pin.
  always @(negedge clk) begin
    if (model_ok) begin
      check("addr",   int'(bus.addr),         m_pc);
      check("enable", int'(bus.enable),       (m_mode == 1 && !bus.stall) ? 1 : 0);
      check("busy",   int'(bus.busy),         (m_mode == 1) ? 1 : 0);
      check("finish", int'(bus.finish),       m_fin);
      check("error",  int'(bus.error),        m_err);
      check("count",  int'(bus.uinstr_count), m_cnt);
      if (pin_on) begin
        if (pin_addr >= 0) check({"pin_", pin_name, "_addr"},   int'(bus.addr),         pin_addr);
        if (pin_cnt  >= 0) check({"pin_", pin_name, "_count"},  int'(bus.uinstr_count), pin_cnt);
        if (pin_busy >= 0) check({"pin_", pin_name, "_busy"},   int'(bus.busy),         pin_busy);
        if (pin_fin  >= 0) check({"pin_", pin_name, "_finish"}, int'(bus.finish),       pin_fin);
        if (pin_err  >= 0) check({"pin_", pin_name, "_error"},  int'(bus.error),        pin_err);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic st, input logic z,
                       input int mb, input int sl, input int jp);
    rst_n         = r;
    bus.start     = s;
    bus.stall     = st;
    bus.Z_flag    = z;
    bus.MBRU      = 7'(mb);
    bus.next_sel  = 3'(sl);
    bus.jump_addr = 7'(jp);
    @(posedge clk);
    #1;
    pin_on = 1'b0;
  endtask

  task automatic run(input int sl, input int jp, input logic z, input int mb);
    drive(1'b1, 1'b0, 1'b0, z, mb, sl, jp);
  endtask

  task automatic pin(input string n, input int a, input int c, input int b, input int f, input int e);
    pin_name = n; pin_addr = a; pin_cnt = c; pin_busy = b; pin_fin = f; pin_err = e;
    pin_on = 1'b1;
  endtask

  initial begin
    // Reset, then start.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    pin("reset", 0, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    pin("start", 0, 0, 1, 0, 0);

    // Increment and dispatch.
    run(0, 0, 1'b0, 0);
    run(0, 0, 1'b0, 0);
    run(0, 0, 1'b0, 0);
    pin("inc3", 3, 3, 1, -1, -1);
    run(2, 0, 1'b0, 20);
    pin("dispatch", 20, 4, 1, -1, -1);

    // Branches, with a start pulse during the run.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 47);
    pin("ign_start", 47, 5, 1, 0, 0);
    run(4, 60, 1'b0, 0);
    pin("jnz_taken", 60, 6, -1, -1, -1);
    run(1, 52, 1'b0, 0);
    run(3, 10, 1'b0, 0);
    pin("jz_not_taken", 53, 8, -1, -1, -1);

    // Stall: reserved select and a would-be-taken JZ must both be ignored.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 7, 10);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 7, 10);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 3, 10);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 3, 10);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 3, 10);
    pin("stall", 53, 8, 1, 0, 0);
    run(3, 10, 1'b1, 0);
    pin("resume_jz", 10, 9, -1, -1, -1);

    // Fetch, jump to 30, halt there with a start pulse.
    run(5, 99, 1'b0, 0);
    pin("fetch", 0, 10, -1, -1, -1);
    run(1, 30, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 6, 0);
    pin("halt", 30, 12, 0, 1, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    pin("done_exit", 30, 12, 0, 0, 0);
    run(0, 0, 1'b0, 0);
    pin("idle_hold", 30, 12, 0, 0, 0);

    // Reserved select aborts.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run(0, 0, 1'b0, 0);
    run(7, 0, 1'b0, 0);
    pin("rsvd_abort", 1, 2, 0, 0, 1);
    run(0, 0, 1'b0, 0);
    pin("err_sticky", 1, 2, 0, 0, 1);

    // Increment at the top address aborts.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    pin("restart_clr", 0, 0, 1, 0, 0);
    run(1, 127, 1'b0, 0);
    run(0, 0, 1'b0, 0);
    pin("wrap_abort", 127, 2, 0, 0, 1);
    run(0, 0, 1'b0, 0);

    // Reset in the middle of a run; start under reset has no effect.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run(0, 0, 1'b0, 0);
    run(0, 0, 1'b0, 0);
    pin("pre_reset", 2, 2, 1, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 6, 0);
    pin("mid_reset", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    pin("start_in_reset", 0, 0, 0, 0, 0);
    run(0, 0, 1'b0, 0);
    run(0, 0, 1'b0, 0);
    pin("post_reset", 0, 0, 0, 0, 0);
    run(0, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
